// File: rtl/viterbi_decoder_k3.sv
// rtl/viterbi_decoder_k3.sv - hard-decision Viterbi decoder, rate 1/2, K=3, register exchange
//
// Decodes the serialized output of a rate-1/2, K=3 convolutional encoder
// (generators 111 and 101, c0 sent first). Two accepted code bits form one
// symbol. Each completed symbol runs add-compare-select over the 4 trellis
// states and updates the register-exchange survivors. The decoded bit is
// taken from the oldest survivor position after TB_DEPTH symbols.
//
// Optional feature macro: VDEC_ERRCNT_EN adds the err_cnt output.
//
// Ports:
//   clock     - system clock, all state updates on posedge
//   reset     - asynchronous active-low reset
//   in        - serial code bit
//   in_valid  - in is accepted on a posedge where in_valid=1
//   out       - decoded information bit, held between strobes
//   out_valid - one-cycle strobe qualifying out
//   err_cnt   - count of ACS steps with no error-free path (VDEC_ERRCNT_EN only)

module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 15,
  parameter int METRIC_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in,
  input  logic        in_valid,
  output logic        out,
  output logic        out_valid
`ifdef VDEC_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  // Candidates carry two extra bits so PM + BM never wraps before saturation.
  localparam int CW    = METRIC_W + 2;
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] PM_MAX = '1;

  logic                phase;
  logic                r0;
  logic [CNT_W-1:0]    sym_cnt;
  logic [METRIC_W-1:0] pm     [4];
  logic [TB_DEPTH-1:0] sv     [4];

  logic [METRIC_W-1:0] pm_new [4];
  logic [TB_DEPTH-1:0] sv_new [4];
  logic [CW-1:0]       cand0  [4];
  logic [CW-1:0]       cand1  [4];
  logic [CW-1:0]       cand   [4];
  logic [CW-1:0]       diff   [4];
  logic [1:0]          psel   [4];
  logic [CW-1:0]       min_c;
  logic [1:0]          best;
  logic                sym_done;

  // Hamming distance between the received pair and the code pair emitted
  // when input bit b leaves predecessor state p.
  function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic b,
                                               input logic a0, input logic a1);
    logic c0;
    logic c1;
    c0 = b ^ p[1] ^ p[0];
    c1 = b ^ p[0];
    return {1'b0, a0 ^ c0} + {1'b0, a1 ^ c1};
  endfunction

  // r1 is the live input bit on the completing edge.
  assign sym_done = in_valid & phase;

  always_comb begin
    min_c = '1;
    best  = 2'd0;
    for (int n = 0; n < 4; n++) begin
      logic [1:0] nn;
      logic [1:0] p0;
      logic [1:0] p1;
      nn = 2'(n);
      p0 = {nn[0], 1'b0};
      p1 = {nn[0], 1'b1};
      cand0[n] = CW'(pm[p0]) + CW'(branch_metric(p0, nn[1], r0, in));
      cand1[n] = CW'(pm[p1]) + CW'(branch_metric(p1, nn[1], r0, in));
      // Ties favour the predecessor whose oldest bit is 0.
      if (cand1[n] < cand0[n]) begin
        psel[n] = p1;
        cand[n] = cand1[n];
      end else begin
        psel[n] = p0;
        cand[n] = cand0[n];
      end
      if (cand[n] < min_c) min_c = cand[n];
    end
    for (int n = 0; n < 4; n++) begin
      logic [1:0] nn;
      nn = 2'(n);
      diff[n] = cand[n] - min_c;
      pm_new[n] = (diff[n] > CW'(PM_MAX)) ? PM_MAX : diff[n][METRIC_W-1:0];
      // Shift the chosen predecessor's history and append this decision.
      sv_new[n] = (sv[psel[n]] << 1) | TB_DEPTH'(nn[1]);
    end
    // Scan downwards so the lowest-index zero-metric state wins.
    for (int n = 3; n >= 0; n--) begin
      if (pm_new[n] == '0) best = 2'(n);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase     <= 1'b0;
      r0        <= 1'b0;
      sym_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      pm[0]     <= '0;
      for (int i = 1; i < 4; i++) pm[i] <= METRIC_W'(3);
      for (int i = 0; i < 4; i++) sv[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        phase <= ~phase;
        if (!phase) begin
          r0 <= in;
        end else begin
          for (int i = 0; i < 4; i++) begin
            pm[i] <= pm_new[i];
            sv[i] <= sv_new[i];
          end
          if (sym_cnt != CNT_W'(TB_DEPTH)) sym_cnt <= sym_cnt + CNT_W'(1);
          // sym_cnt still holds n-1 here, so n >= TB_DEPTH.
          if (sym_cnt >= CNT_W'(TB_DEPTH - 1)) begin
            out       <= sv_new[best][TB_DEPTH-1];
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef VDEC_ERRCNT_EN
  // A nonzero pre-normalization minimum means every path disagrees with the
  // received stream somewhere in this step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_cnt <= 16'h0000;
    end else if (sym_done && (min_c != '0) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/viterbi_decoder_k3.md
Name: viterbi_decoder_k3

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code. Sits directly downstream of the convolutional encoder stage.
- Consumes the encoder's serialized code-bit stream, two code bits per information bit, and re-pairs them into symbols.
- Runs add-compare-select over 4 trellis states and recovers information bits by register exchange, with fixed decision depth TB_DEPTH.

Parameters:
- TB_DEPTH, 15: survivor register length in symbols; decode latency in symbols; legal range 4..32.
- METRIC_W, 5: path-metric width in bits; minimum 3.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in  input  1  serial code bit.
- in_valid  input  1  in is sampled on a posedge where in_valid=1; no backpressure.
- out  output  1  decoded information bit.
- out_valid  output  1  one-cycle strobe qualifying out.
- err_cnt  output  16  corrected-error indicator count; present only with VDEC_ERRCNT_EN.

Behaviour:
- Reset value of outputs (reset=0, asynchronous):
  - out=0, out_valid=0, err_cnt=0.
  - phase=0, symbol counter=0, all survivors=0.
  - Path metrics: PM[0]=0, PM[1..3]=3.
  - Reset mid-stream discards any half-received symbol and all history.
- Code definition:
  - State S={b(t-1), b(t-2)}.
  - Input bit b takes S to N={b, S[1]}.
  - c0=b^S[1]^S[0] (generator 111), c1=b^S[0] (generator 101).
  - Serial order per symbol: c0 first, then c1.
- Symbol assembly:
  - phase toggles on each accepted bit.
  - phase=0: latch in as r0.
  - phase=1: r1=in; the symbol is complete and the ACS step fires on that same clock edge.
  - Cycles with in_valid=0 hold all state; gaps of any length are legal, including between c0 and c1.
- ACS, one per completed symbol:
  - Predecessors of N are P0={N[0],0} and P1={N[0],1}.
  - Branch metric BM = Hamming distance of (r0,r1) to the expected (c0,c1), range 0..2.
  - Candidate Ci = PM[Pi] + BM_i. Select P1 only if C1 < C0; ties pick P0.
- Normalization:
  - Each step, subtract min over N of the selected candidates from all new metrics, so min PM = 0 after every step.
  - Any value exceeding 2^METRIC_W-1 saturates to all-ones.
- Survivors (register exchange):
  - SV[N] <= {SV[Psel][TB_DEPTH-2:0], N[1]}, TB_DEPTH bits wide.
  - MSB is the oldest decision.
- Output:
  - best = lowest-index state with normalized PM = 0.
  - On the clock after symbol n completes (n counted from 1), if n >= TB_DEPTH: out = SV_new[best][TB_DEPTH-1] (information bit n-TB_DEPTH+1), out_valid=1 for one cycle.
  - Otherwise out_valid=0 and out holds its previous value.
  - The symbol counter saturates at TB_DEPTH.
- Flush: the last TB_DEPTH-1 information bits appear only after the stream is extended with further symbols. The upstream appends TB_DEPTH zero bits (encoder tail); the decoder has no flush port.
- Throughput: at most one decoded bit per 2 accepted code bits; no internal stalls.

Optional Feature:
- Macro: VDEC_ERRCNT_EN.
- Defined:
  - err_cnt port exists; reset to 0.
  - Increments by 1 on each ACS step whose pre-normalization minimum candidate exceeds 0, meaning no error-free path survives that step.
  - Saturates at 16'hFFFF.
- Undefined: port and counter logic absent; decode behaviour identical.

Test Plan:
- All-zero stream, 40 pairs of 00 with in_valid=1 continuously -> first out_valid after symbol 15; 26 strobes total, all out=0.
- Info 1,0,1,1,0,0 plus 15 zero bits, encoded as serial 1,1,1,0,0,0,0,1,0,1,1,1 then zero pairs -> out sequence 1,0,1,1,0,0, first bit on the cycle after symbol 15.
- Same stream with the 3rd serial bit flipped (1->0) -> identical decoded output; err_cnt=1 when VDEC_ERRCNT_EN is defined.
- Same stream with in_valid deasserted 3 cycles between every bit, including mid-symbol -> identical decoded sequence; out_valid only after c1 completions.
- Reset pulsed low after 7 serial bits, then the full test vector replayed -> no out_valid before symbol 15 of the new stream; correct decode; err_cnt=0.
- 200 symbols of random info with one bit error every 20 symbols, METRIC_W=5 -> zero decode errors; metrics never saturate; err_cnt=10.
